// File: rtl/fpu_pkg.sv
// Shared definitions for the fp16 inverse-square-root arbiter: FSM encoding,
// the canonical quiet NaN and the layout of the unit's OFUF flags.
package fpu_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    localparam int OFUF_OVERFLOW  = 1;
    localparam int OFUF_UNDERFLOW = 0;

    typedef struct packed {
        logic [15:0] result;
        logic [1:0]  ofuf;
        logic        timeout;
    } isr_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at a
// rotating pointer; the pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    // Scan from the far offset back toward the pointer so the nearest requester wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fpu_invsqrt_arbiter.sv
// Shares one fastInvSqrt unit among N_REQ requesters: round-robin accept,
// start pulse, wait for done (with watchdog), single response channel.
module fpu_invsqrt_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [16*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_result,
    output logic [1:0]          rsp_ofuf,
    output logic                rsp_timeout,
    output logic [15:0]         isr_xin,
    output logic                isr_start,
    input  logic                isr_done,
    input  logic [15:0]         isr_result,
    input  logic [1:0]          isr_ofuf
);

    // Handshake rule: a request transfers in a cycle where req_valid[i] and
    // req_ready[i] are both high; a response transfers where rsp_valid and
    // rsp_ready are both high, and rsp_* hold until then.

    logic [1:0]       state;
    logic [N_REQ-1:0] grant;
    logic             handshake;
    logic [ID_W-1:0]  grant_id;
    logic [15:0]      grant_x;
    logic [15:0]      wd_cnt;
    isr_rsp_t         rsp_q;

    assign req_ready = (state == ST_IDLE && !reset) ? grant : '0;
    assign handshake = |req_ready;
    assign isr_start = (state == ST_LAUNCH);
    assign rsp_valid = (state == ST_RESP);

    assign rsp_result  = rsp_q.result;
    assign rsp_ofuf    = rsp_q.ofuf;
    assign rsp_timeout = rsp_q.timeout;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (handshake),
        .grant   (grant)
    );

    always_comb begin
        grant_id = '0;
        grant_x  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                grant_x  = req_x[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            isr_xin <= '0;
            rsp_id  <= '0;
            rsp_q   <= '0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        isr_xin <= grant_x;
                        rsp_id  <= grant_id;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done is checked first so a coincident done beats the watchdog.
                    if (isr_done) begin
                        rsp_q.result                 <= isr_result;
                        rsp_q.ofuf[OFUF_OVERFLOW]    <= isr_ofuf[OFUF_OVERFLOW];
                        rsp_q.ofuf[OFUF_UNDERFLOW]   <= isr_ofuf[OFUF_UNDERFLOW];
                        rsp_q.timeout                <= 1'b0;
                        state                        <= ST_RESP;
                    end else if (wd_cnt == 16'(TIMEOUT)) begin
                        rsp_q.result  <= FP16_QNAN;
                        rsp_q.ofuf    <= '0;
                        rsp_q.timeout <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_invsqrt_arbiter.sv
// Bench for fpu_invsqrt_arbiter: behavioural unit stub, round-robin reference
// model, response scoreboard and directed plus random scenarios.
module tb_fpu_invsqrt_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_x = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_result;
    logic [1:0]      rsp_ofuf;
    logic            rsp_timeout;
    logic [15:0]     isr_xin;
    logic            isr_start;
    logic            isr_done;
    logic [15:0]     isr_result;
    logic [1:0]      isr_ofuf;

    fpu_invsqrt_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_ofuf    (rsp_ofuf),
        .rsp_timeout (rsp_timeout),
        .isr_xin     (isr_xin),
        .isr_start   (isr_start),
        .isr_done    (isr_done),
        .isr_result  (isr_result),
        .isr_ofuf    (isr_ofuf)
    );

    // ---------------- unit behaviour ----------------
    function automatic logic [15:0] ref_result(input logic [15:0] x);
        if (x == 16'h50BB) return 16'h3133;
        if (x == 16'h4DE1) return 16'h3298;
        return {x[7:0], ~x[15:8]};
    endfunction

    function automatic logic [1:0] ref_ofuf(input logic [15:0] x);
        if (x == 16'h50BB || x == 16'h4DE1) return 2'b00;
        return x[9:8];
    endfunction

    int   op_lat = 0;
    logic op_never = 1'b0;
    logic [15:0] stub_x = '0;
    int   stub_cnt = 0;
    logic stub_busy = 1'b0;
    initial isr_done = 1'b0;

    // done appears lat cycles into WAIT (lat = 0: first WAIT cycle); held until next start.
    always @(posedge clk) begin
        if (isr_start) begin
            stub_x    <= isr_xin;
            stub_cnt  <= op_lat;
            isr_done  <= !op_never && op_lat == 0;
            stub_busy <= !op_never && op_lat != 0;
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                isr_done  <= 1'b1;
                stub_busy <= 1'b0;
            end
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign isr_result = ref_result(stub_x);
    assign isr_ofuf   = ref_ofuf(stub_x);

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];
    int   grant_log[$];
    int   cyc = 0;
    int   ptr = 0;
    logic busy = 1'b0;
    int   hs_cyc = 0;
    int   exp_rsp_cyc = 0;
    logic [15:0] cur_x = '0;
    logic [N-1:0] hs_mask = '0;
    int   hs_count = 0;
    int   force_lat = -1;
    logic force_never = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (g == 0 && v[(p + k) % N]) g[(p + k) % N] = 1'b1;
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_ready;
        int g, lat;
        logic never, tmo;
        logic [15:0] x;
        cyc++;
        hs_mask = '0;
        if (reset) begin
            check("reset_outputs", {rsp_valid, req_ready, isr_start, isr_xin, rsp_id,
                                    rsp_result, rsp_ofuf, rsp_timeout}, '0);
            busy = 1'b0;
            ptr  = 0;
            exp_q.delete();
        end else begin
            exp_ready = busy ? '0 : rr_pick(req_valid, ptr);
            if (req_ready != 0) grant_log.push_back(onehot_idx(req_ready));
            check("req_ready", req_ready, exp_ready);
            check("isr_start", isr_start, busy && cyc == hs_cyc + 1);
            if (busy && cyc > hs_cyc) check("isr_xin", isr_xin, cur_x);
            check("rsp_valid", rsp_valid, busy && cyc >= exp_rsp_cyc);
            if (rsp_valid && exp_q.size() != 0) begin
                check("rsp_fields", {rsp_id, rsp_result, rsp_ofuf, rsp_timeout}, exp_q[0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end
            if (exp_ready != 0) begin
                g     = onehot_idx(exp_ready);
                x     = req_x[g*16 +: 16];
                lat   = (force_lat >= 0) ? force_lat : $urandom_range(0, 20);
                never = force_never || (force_lat < 0 && $urandom_range(0, 99) < 8);
                tmo   = never || lat > TO;
                op_lat   = lat;
                op_never = never;
                exp_q.push_back({2'(g), tmo ? 16'h7E00 : ref_result(x),
                                 tmo ? 2'b00 : ref_ofuf(x), tmo});
                exp_rsp_cyc = cyc + 3 + (tmo ? TO : lat);
                hs_cyc  = cyc;
                cur_x   = x;
                busy    = 1'b1;
                ptr     = (g + 1) % N;
                hs_mask = exp_ready;
                hs_count++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_hs(input int target, input int bound);
        int n;
        n = 0;
        while (hs_count < target && n < bound) begin
            step();
            n++;
        end
        if (hs_count < target) check("grant_wait_expired", 1, 0);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < bound) begin
            step();
            n++;
        end
        if (busy || exp_q.size() != 0) check("response_wait_expired", 1, 0);
    endtask

    task automatic single_op(input int id, input logic [15:0] x, input int lat, input logic never);
        force_lat   = lat;
        force_never = never;
        req_x[id*16 +: 16] = x;
        req_valid[id] = 1'b1;
        wait_hs(hs_count + 1, 20);
        req_valid = '0;
        wait_idle(60);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, n;
        repeat (3) step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        step();

        // single request
        single_op(0, 16'h50BB, 3, 1'b0);

        // round robin from a fresh pointer
        apply_reset();
        grant_log.delete();
        req_x = {$urandom(), $urandom()};
        req_x[2*16 +: 16] = 16'h4DE1;
        force_lat = 2;
        force_never = 1'b0;
        req_valid = '1;
        wait_hs(hs_count + 5, 60);
        req_valid = '0;
        wait_idle(60);
        check("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("rr_order_%0d", i), grant_log[i], i % N);

        // backpressure: everyone waiting while the response is held
        rsp_ready = 1'b0;
        force_lat = 4;
        req_valid = '1;
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        check("bp_rsp_seen", rsp_valid, 1'b1);
        base = hs_count;
        repeat (20) step();
        check("bp_no_new_grant", hs_count, base);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(20);

        // watchdog and done/timeout coincidence
        single_op(1, 16'h1234, 0, 1'b1);
        single_op(2, 16'h5678, TO, 1'b0);
        single_op(3, 16'h3C00, TO - 1, 1'b0);
        single_op(0, 16'h0400, 0, 1'b0);

        // reset mid-WAIT, then requester 0 wins first
        force_lat = 10;
        force_never = 1'b0;
        req_x[1*16 +: 16] = 16'hBEEF;
        req_valid[1] = 1'b1;
        wait_hs(hs_count + 1, 20);
        req_valid = '0;
        repeat (4) step();
        apply_reset();
        check("post_reset_no_rsp", rsp_valid, 1'b0);
        grant_log.delete();
        req_x[0 +: 16] = 16'h50BB;
        req_valid = '1;
        wait_hs(hs_count + 1, 20);
        req_valid = '0;
        wait_idle(60);
        check("post_reset_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // randomized traffic
        force_lat = -1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hs_mask[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
                if (!req_valid[i] && !hs_mask[i] && $urandom_range(0, 99) < 30) begin
                    req_valid[i] = 1'b1;
                    req_x[i*16 +: 16] = 16'($urandom());
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
